// File: rtl/tone_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// Package: tone_pkg
// Purpose: Shared types and constants for the tone scheduler slice.
//   - lane_t   : 2-bit lane index (lane i corresponds to BTNS[i+1])
//   - state_t  : scheduler FSM states {IDLE, PLAY, GAP}
//   - FREQ_*   : half-period counts fed to the tone generator
//   - lane_freq: maps a lane index to its half-period count
// Lane map: 0 = D (BTNS[1]), 1 = C (BTNS[2]), 2 = G (BTNS[3]), 3 = E (BTNS[4]).
// ----------------------------------------------------------------------------
package tone_pkg;

    localparam int FREQ_W = 29;

    typedef logic [1:0] lane_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam lane_t LANE_D = 2'd0;
    localparam lane_t LANE_C = 2'd1;
    localparam lane_t LANE_G = 2'd2;
    localparam lane_t LANE_E = 2'd3;

    localparam logic [FREQ_W-1:0] FREQ_C = 29'd191112;
    localparam logic [FREQ_W-1:0] FREQ_D = 29'd170262;
    localparam logic [FREQ_W-1:0] FREQ_E = 29'd151686;
    localparam logic [FREQ_W-1:0] FREQ_G = 29'd127551;

    function automatic logic [FREQ_W-1:0] lane_freq(input lane_t lane);
        case (lane)
            LANE_D:  return FREQ_D;
            LANE_C:  return FREQ_C;
            LANE_G:  return FREQ_G;
            default: return FREQ_E;
        endcase
    endfunction

endpackage

// File: rtl/tone_scheduler_lane_arbiter.sv
// ----------------------------------------------------------------------------
// Module: lane_arbiter
// Purpose: Picks one requesting lane for the shared tone generator.
//   Purely combinational.
//   Default build : fixed priority E > G > D > C.
//   TONE_RR_EN    : round-robin, search starts at rr_ptr and moves up with wrap.
// Ports:
//   req         in   4  synchronised lane requests (lane i = BTNS[i+1])
//   rr_ptr      in   2  round-robin start lane (present only with TONE_RR_EN)
//   grant       out  4  one-hot granted lane, 0 when nothing is requested
//   grant_idx   out  2  index of the granted lane (don't-care when !grant_valid)
//   grant_valid out  1  at least one lane is requesting
// ----------------------------------------------------------------------------
module lane_arbiter
    import tone_pkg::*;
(
    input  logic [3:0] req,
`ifdef TONE_RR_EN
    input  lane_t      rr_ptr,
`endif
    output logic [3:0] grant,
    output lane_t      grant_idx,
    output logic       grant_valid
);

`ifdef TONE_RR_EN
    lane_t probe;
`endif

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        grant       = '0;
        grant_idx   = LANE_D;
        grant_valid = 1'b0;
`ifdef TONE_RR_EN
        probe       = rr_ptr;
        // Walk from the farthest lane back to rr_ptr itself; the last hit is
        // the one closest to rr_ptr, which is the round-robin winner.
        for (int k = 3; k >= 0; k--) begin
            probe = rr_ptr + lane_t'(k);
            if (req[probe]) begin
                grant_idx   = probe;
                grant_valid = 1'b1;
            end
        end
`else
        if (req[LANE_E]) begin
            grant_idx   = LANE_E;
            grant_valid = 1'b1;
        end else if (req[LANE_G]) begin
            grant_idx   = LANE_G;
            grant_valid = 1'b1;
        end else if (req[LANE_D]) begin
            grant_idx   = LANE_D;
            grant_valid = 1'b1;
        end else if (req[LANE_C]) begin
            grant_idx   = LANE_C;
            grant_valid = 1'b1;
        end
`endif
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/tone_scheduler.sv
// ----------------------------------------------------------------------------
// Module: tone_scheduler
// Purpose: Shares one tone generator between the four arrow-lane buttons.
//   Grants one lane at a time, holds each note for at least MIN_HOLD_CYC
//   cycles, then inserts GAP_CYC silent cycles before re-arbitrating.
//   No preemption: lanes pressed during a note wait for the next arbitration.
// Configuration macro: TONE_RR_EN (round-robin arbitration; default fixed
//   priority E > G > D > C).
// Parameters:
//   MIN_HOLD_CYC  minimum cycles a granted note sounds (default 8)
//   GAP_CYC       silent cycles after a note; 0 returns straight to IDLE
// Ports:
//   CLK         in   1   system clock
//   RST         in   1   asynchronous active-high reset
//   BTNS        in   5   raw buttons: [0]=mute [1]=D [2]=C [3]=G [4]=E
//   frequency   out  29  half-period count for the tone generator, 0 = silence
//   button      out  4   one-hot granted lane (button[i] <-> BTNS[i+1])
//   note_start  out  1   one-cycle pulse when a new note is granted
// Latency: a button rising before edge k is granted at edge k+2.
// ----------------------------------------------------------------------------
module tone_scheduler
    import tone_pkg::*;
#(
    parameter int MIN_HOLD_CYC = 8,
    parameter int GAP_CYC      = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [4:0]        BTNS,
    output logic [FREQ_W-1:0] frequency,
    output logic [3:0]        button,
    output logic              note_start
);

    localparam int CNT_MAX = (MIN_HOLD_CYC > GAP_CYC) ? MIN_HOLD_CYC : GAP_CYC;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MIN_HOLD_CYC);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    // ------------------------------------------------------------------
    // Input synchroniser: raw buttons are asynchronous to CLK.
    // ------------------------------------------------------------------
    logic [4:0] btn_meta;
    logic [4:0] btn_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            btn_meta <= BTNS;
            btn_sync <= btn_meta;
        end
    end

    logic [3:0] req;
    logic       mute;

    assign req  = btn_sync[4:1];
    assign mute = btn_sync[0];

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [3:0] grant;
    lane_t      grant_idx;
    logic       grant_valid;
    state_t     state;

`ifdef TONE_RR_EN
    lane_t rr_ptr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr_ptr <= LANE_D;
        end else if (state == IDLE && grant_valid) begin
            rr_ptr <= grant_idx + lane_t'(1);
        end
    end
`endif

    lane_arbiter u_arbiter (
        .req         (req),
`ifdef TONE_RR_EN
        .rr_ptr      (rr_ptr),
`endif
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // ------------------------------------------------------------------
    // Note timing
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  counter;
    lane_t             cur_lane;
    logic [CNT_W-1:0]  hold_next;
    logic              keep_playing;
    logic [FREQ_W-1:0] play_freq;
    logic [FREQ_W-1:0] grant_freq;

    always_comb begin
        hold_next    = (counter == HOLD_LIMIT) ? counter : counter + CNT_ONE;
        // The count after this edge decides, so a tap sounds exactly
        // MIN_HOLD_CYC cycles rather than one extra.
        keep_playing = req[cur_lane] || (hold_next < HOLD_LIMIT);
        // Mute only silences the output; the FSM is unaffected.
        play_freq    = mute ? '0 : lane_freq(cur_lane);
        grant_freq   = mute ? '0 : lane_freq(grant_idx);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            counter    <= '0;
            cur_lane   <= LANE_D;
            frequency  <= '0;
            button     <= '0;
            note_start <= 1'b0;
        end else begin
            note_start <= 1'b0;
            case (state)
                IDLE: begin
                    frequency <= '0;
                    button    <= '0;
                    if (grant_valid) begin
                        cur_lane   <= grant_idx;
                        frequency  <= grant_freq;
                        button     <= grant;
                        note_start <= 1'b1;
                        counter    <= '0;
                        state      <= PLAY;
                    end
                end

                PLAY: begin
                    if (keep_playing) begin
                        counter   <= hold_next;
                        frequency <= play_freq;
                    end else begin
                        counter   <= '0;
                        frequency <= '0;
                        button    <= '0;
                        state     <= (GAP_CYC > 0) ? GAP : IDLE;
                    end
                end

                GAP: begin
                    frequency <= '0;
                    button    <= '0;
                    if (counter == GAP_LAST) begin
                        counter <= '0;
                        state   <= IDLE;
                    end else begin
                        counter <= counter + CNT_ONE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    counter   <= '0;
                    frequency <= '0;
                    button    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_scheduler.sv
// ----------------------------------------------------------------------------
// Testbench: tb_tone_scheduler
// Directed scenarios followed by randomised button traffic. The reference
// model works on edge timestamps: a button value seen at edge e is acted on
// at edge e+2, a note may end once MIN_HOLD cycles have elapsed since its
// grant and its button is gone, and the next grant is allowed GAP+1 edges
// after the note ends.
// ----------------------------------------------------------------------------
module tb_tone_scheduler;

    localparam int MIN_HOLD = 8;
    localparam int GAP      = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  BTNS;
    logic [28:0] frequency;
    logic [3:0]  button;
    logic        note_start;

    tone_scheduler #(
        .MIN_HOLD_CYC (MIN_HOLD),
        .GAP_CYC      (GAP)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .BTNS       (BTNS),
        .frequency  (frequency),
        .button     (button),
        .note_start (note_start)
    );

    always #5 CLK = ~CLK;

    // Half-period per lane: D, C, G, E (lane i is button BTNS[i+1]).
    int unsigned lane_period [4] = '{170262, 191112, 127551, 151686};

    int n_total  = 0;
    int n_passed = 0;
    int n_failed = 0;

    // Reference model state.
    logic [4:0]  m_hist[$];
    int          m_edge;
    bit          m_play;
    int          m_lane;
    int          m_start;
    int          m_next_ok;
    int          m_rr;
    int unsigned exp_freq;
    logic [3:0]  exp_btn;
    logic        exp_ns;

    // Scenario-level tallies.
    int cnt_ns;
    int cnt_tone;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else begin
            n_failed++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r);
`ifdef TONE_RR_EN
        for (int k = 0; k < 4; k++) begin
            if (r[(m_rr + k) % 4]) return (m_rr + k) % 4;
        end
`else
        int order [4] = '{3, 2, 0, 1};
        for (int k = 0; k < 4; k++) begin
            if (r[order[k]]) return order[k];
        end
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_edge    = 0;
        m_play    = 1'b0;
        m_lane    = 0;
        m_start   = 0;
        m_next_ok = 0;
        m_rr      = 0;
    endtask

    task automatic model_step();
        logic [4:0] used;
        m_hist.push_back(BTNS);
        if (m_hist.size() > 3) void'(m_hist.pop_front());
        used   = (m_hist.size() == 3) ? m_hist[0] : 5'd0;
        exp_ns = 1'b0;
        if (m_play) begin
            if (!used[m_lane + 1] && (m_edge - m_start) >= MIN_HOLD) begin
                m_play    = 1'b0;
                m_next_ok = m_edge + GAP + 1;
            end
        end else if (m_edge >= m_next_ok && used[4:1] != 4'd0) begin
            m_lane  = pick(used[4:1]);
            m_play  = 1'b1;
            m_start = m_edge;
            m_rr    = (m_lane + 1) % 4;
            exp_ns  = 1'b1;
        end
        exp_btn  = m_play ? (4'b0001 << m_lane) : 4'b0000;
        exp_freq = (m_play && !used[0]) ? lane_period[m_lane] : 0;
        m_edge++;
    endtask

    // One clock: model advances at the edge, outputs compared 1 time unit later.
    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
        check($sformatf("frequency@%0d", m_edge), {3'b0, frequency}, exp_freq);
        check($sformatf("button@%0d", m_edge), {28'b0, button}, {28'b0, exp_btn});
        check($sformatf("note_start@%0d", m_edge), {31'b0, note_start}, {31'b0, exp_ns});
        if (note_start) cnt_ns++;
        if (frequency != 0) cnt_tone++;
        @(negedge CLK);
    endtask

    task automatic run(input logic [4:0] b, input int n);
        BTNS = b;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        RST  = 1'b1;
        BTNS = 5'd0;
        model_reset();
        repeat (3) @(negedge CLK);
        check("reset_frequency", {3'b0, frequency}, 32'd0);
        check("reset_button", {28'b0, button}, 32'd0);
        check("reset_note_start", {31'b0, note_start}, 32'd0);
        RST = 1'b0;

        // Hold C for 20 cycles: one note, then silence.
        cnt_ns = 0;
        run(5'b00100, 20);
        run(5'b00000, 12);
        check("hold_c_note_starts", cnt_ns, 32'd1);

        // One-cycle tap on D sounds for exactly MIN_HOLD cycles.
        cnt_tone = 0;
        run(5'b00010, 1);
        run(5'b00000, 16);
        check("tap_d_tone_cycles", cnt_tone, MIN_HOLD);

        // D and E together.
        run(5'b10010, 30);
        run(5'b00000, 12);

        // Mute in the middle of an E note.
        run(5'b10000, 5);
        run(5'b10001, 4);
        run(5'b10000, 4);
        run(5'b00000, 14);

        // G pressed during a D note waits for D plus the gap.
        cnt_ns = 0;
        run(5'b00010, 3);
        run(5'b01010, 6);
        run(5'b01000, 15);
        run(5'b00000, 14);
        check("d_then_g_note_starts", cnt_ns, 32'd2);

        // Reset in the middle of a C note, C still held afterwards.
        run(5'b00100, 5);
        RST = 1'b1;
        #1;
        check("midnote_reset_frequency", {3'b0, frequency}, 32'd0);
        check("midnote_reset_button", {28'b0, button}, 32'd0);
        check("midnote_reset_note_start", {31'b0, note_start}, 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        model_reset();
        run(5'b00100, 12);
        run(5'b00000, 14);

        // Random traffic: mixed lanes, occasional mute, random hold lengths.
        for (int s = 0; s < 45; s++) begin
            logic [4:0] b;
            b      = 5'($urandom_range(0, 31));
            b[0]   = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) b[4:1] = 4'd0;
            run(b, $urandom_range(1, 12));
        end
        run(5'b00000, 16);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
